// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// im_loader : boot loader; byte stream -> big-endian words -> IM from addr 0.
// Optional trailing XOR checksum byte when IM_LOADER_CHECKSUM_EN is defined.
// Revision  : 1.0
// ============================================================================
module im_loader #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_FLUSH = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERR   = 3'd5;
`ifdef IM_LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHK   = 3'd6;
`endif
   localparam logic [31:0] CAP = 32'd1 << ADDR_W;

   logic [2:0]        state_q, state_d;
   logic [1:0]        lane_q, lane_d;
   logic [23:0]       shift_q, shift_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              accept;
   logic              word_done;
   logic [31:0]       word;
   logic [ADDR_W:0]   cnt_inc;

   assign accept    = in_valid && ready_q;
   assign word_done = accept && (lane_q == 2'd3);
   assign word      = {shift_q, in_data};
   assign cnt_inc   = cnt_q + (ADDR_W+1)'(1);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_HDR;
         end
         S_HDR: begin
            if (word_done) begin
               state_d = (word == 32'd0 || word > CAP) ? S_ERR : S_DATA;
            end
         end
         S_DATA: begin
            if (word_done && cnt_inc == n_q) state_d = S_FLUSH;
         end
         S_FLUSH: begin
`ifdef IM_LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_DONE;
`endif
         end
`ifdef IM_LOADER_CHECKSUM_EN
         S_CHK: begin
            if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: byte assembly, word count, IM write strobe
   always_comb begin
      lane_d  = lane_q;
      shift_d = shift_q;
      n_d     = n_q;
      cnt_d   = cnt_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
      xor_d   = xor_q;
`endif
      if (state_q != S_HDR && state_d == S_HDR) begin
         lane_d = 2'd0;
         cnt_d  = '0;
`ifdef IM_LOADER_CHECKSUM_EN
         xor_d  = 8'd0;
`endif
      end else if (accept && (state_q == S_HDR || state_q == S_DATA)) begin
         lane_d  = lane_q + 2'd1;
         shift_d = {shift_q[15:0], in_data};
         if (state_q == S_HDR && lane_q == 2'd3) begin
            n_d = word[ADDR_W:0];
         end
         if (state_q == S_DATA) begin
`ifdef IM_LOADER_CHECKSUM_EN
            xor_d = xor_q ^ in_data;
`endif
            if (lane_q == 2'd3) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = word;
               cnt_d   = cnt_inc;
            end
         end
      end
   end

   // Status outputs decoded from the state being entered, so they register with it
   always_comb begin
      ready_d     = (state_d == S_HDR) || (state_d == S_DATA);
      busy_d      = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_FLUSH);
`ifdef IM_LOADER_CHECKSUM_EN
      ready_d     = ready_d || (state_d == S_CHK);
      busy_d      = busy_d  || (state_d == S_CHK);
`endif
      done_d      = (state_d == S_DONE);
      error_d     = (state_d == S_ERR);
      cpu_reset_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q      <= 2'd0;
         shift_q     <= 24'd0;
         n_q         <= '0;
         cnt_q       <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
         xor_q       <= 8'd0;
`endif
         ready_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         lane_q      <= lane_d;
         shift_q     <= shift_d;
         n_q         <= n_d;
         cnt_q       <= cnt_d;
`ifdef IM_LOADER_CHECKSUM_EN
         xor_q       <= xor_d;
`endif
         ready_q     <= ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign in_ready     = ready_q;
   assign im_we        = we_q;
   assign im_addr      = addr_q;
   assign im_wdata     = wdata_q;
   assign cpu_reset    = cpu_reset_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// tb_im_loader: directed loads; every IM write is checked against words rebuilt
// from the bytes the bench saw accepted since the last start.
module tb_im_loader;
   localparam int ADDR_W = 5;
   localparam int CAP    = 1 << ADDR_W;
`ifdef IM_LOADER_CHECKSUM_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif
   localparam int DONE_LAT = CHK_EN ? 1 : 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   im_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_we_cyc = 0;
   bit nogap = 1'b0;

   logic [7:0]  acc_q[$];     // bytes accepted since the last start
   logic [31:0] wr_data[$];   // IM writes observed since the last start
   int          wr_addr[$];
   logic [7:0]  stream[$];
   logic [31:0] words[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] q_word(input int base);
      return {acc_q[base], acc_q[base+1], acc_q[base+2], acc_q[base+3]};
   endfunction

   // Model: header gives N, data word k is bytes 4+4k..7+4k, written at address k
   always @(negedge clk) begin
      int     k;
      longint n;
      bit     legal, present;
      cyc++;
      chk("cpu_reset_vs_done", 64'(cpu_reset), 64'(!done));
      chk("flags_exclusive", 64'((int'(busy) + int'(done) + int'(error)) <= 1), 64'd1);
      if (in_ready) chk("ready_only_when_busy", 64'(busy), 64'd1);
      if (im_we) begin
         k       = wr_data.size();
         n       = (acc_q.size() >= 4) ? longint'(q_word(0)) : 0;
         legal   = (n >= 1) && (n <= CAP) && (k < n);
         present = acc_q.size() >= 8 + 4*k;
         chk("we_allowed", 64'(legal), 64'd1);
         chk("we_bytes_present", 64'(present), 64'd1);
         chk("we_cpu_reset", 64'(cpu_reset), 64'd1);
         if (legal && present) begin
            chk("we_addr", 64'(im_addr), 64'(k));
            chk("we_data", 64'(im_wdata), 64'(q_word(4 + 4*k)));
            chk("we_words_loaded", 64'(words_loaded), 64'(k + 1));
         end
         if (nogap && k > 0) chk("we_spacing", 64'(cyc - last_we_cyc), 64'd4);
         last_we_cyc = cyc;
         wr_data.push_back(im_wdata);
         wr_addr.push_back(int'(im_addr));
      end
      if (in_valid && in_ready && !reset) acc_q.push_back(in_data);
   end

   function automatic void build(input logic [31:0] n, input bit add_chk);
      logic [7:0] x;
      x = 8'h00;
      stream.delete();
      for (int i = 3; i >= 0; i--) stream.push_back(n[8*i +: 8]);
      foreach (words[w]) begin
         for (int i = 3; i >= 0; i--) begin
            stream.push_back(words[w][8*i +: 8]);
            x = x ^ words[w][8*i +: 8];
         end
      end
      if (add_chk && CHK_EN) stream.push_back(x);
   endfunction

   task automatic do_start();
      start = 1'b1;
      acc_q.delete();
      wr_data.delete();
      wr_addr.delete();
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Drives stream[lo..hi-1]; returns 1ns after the edge accepting the last byte
   task automatic send(input int lo, input int hi, input bit gaps);
      int t;
      bit got;
      for (int i = lo; i < hi; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data  = 8'hEE;
               @(posedge clk); #1;
            end
         end
         in_valid = 1'b1;
         in_data  = stream[i];
         t   = 0;
         got = 1'b0;
         while (!got) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk); #1;
            t++;
            if (!got && t > 50) begin
               chk("send_timeout", 64'd0, 64'd1);
               in_valid = 1'b0;
               return;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!(done || error) && lat < budget);
      if (!(done || error)) chk("end_timeout", 64'd0, 64'd1);
   endtask

   task automatic chk_reset_vals();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_im_we", 64'(im_we), 64'd0);
      chk("rst_im_addr", 64'(im_addr), 64'd0);
      chk("rst_im_wdata", 64'(im_wdata), 64'd0);
      chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_words_loaded", 64'(words_loaded), 64'd0);
   endtask

   task automatic load_example();
      words.delete();
      words.push_back(32'h24080005);
      words.push_back(32'h0000000C);
      build(32'd2, 1'b1);
   endtask

   initial begin
      int lat;
      int nacc;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_reset_vals();
      reset = 1'b0;
      @(posedge clk); #1;

      // Basic two-word load
      do_start();
      load_example();
      if (CHK_EN) chk("example_checksum", 64'(stream[stream.size()-1]), 64'h25);
      send(0, stream.size(), 1'b0);
      wait_end(20, lat);
      chk("done_latency", 64'(lat), 64'(DONE_LAT));
      chk("ex_done", 64'(done), 64'd1);
      chk("ex_cpu_reset", 64'(cpu_reset), 64'd0);
      chk("ex_words_loaded", 64'(words_loaded), 64'd2);
      chk("ex_nwrites", 64'(wr_data.size()), 64'd2);
      if (wr_data.size() == 2) begin
         chk("ex_word0", 64'(wr_data[0]), 64'h24080005);
         chk("ex_word1", 64'(wr_data[1]), 64'h0000000C);
         chk("ex_addr1", 64'(wr_addr[1]), 64'd1);
      end

      // Source keeps offering bytes while DONE: none may be taken
      nacc = acc_q.size();
      in_valid = 1'b1;
      in_data  = 8'hFF;
      repeat (6) @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("no_accept_in_done", 64'(acc_q.size()), 64'(nacc));

      // Zero-length header
      do_start();
      chk("restart_cpu_reset", 64'(cpu_reset), 64'd1);
      words.delete();
      build(32'd0, 1'b0);
      send(0, 4, 1'b0);
      wait_end(10, lat);
      chk("hdr0_latency", 64'(lat), 64'd1);
      chk("hdr0_error", 64'(error), 64'd1);
      chk("hdr0_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("hdr0_nwrites", 64'(wr_data.size()), 64'd0);

      // Oversize header (capacity + 1)
      do_start();
      build(32'h00000021, 1'b0);
      send(0, 4, 1'b0);
      wait_end(10, lat);
      chk("hdr33_error", 64'(error), 64'd1);
      chk("hdr33_cpu_reset", 64'(cpu_reset), 64'd1);
      repeat (3) @(negedge clk);
      chk("hdr33_nwrites", 64'(wr_data.size()), 64'd0);

      // Recovery from ERR with a gapped stream
      @(posedge clk); #1;
      do_start();
      load_example();
      send(0, stream.size(), 1'b1);
      wait_end(20, lat);
      chk("gap_done", 64'(done), 64'd1);
      chk("gap_nwrites", 64'(wr_data.size()), 64'd2);
      if (wr_data.size() == 2) begin
         chk("gap_word0", 64'(wr_data[0]), 64'h24080005);
         chk("gap_word1", 64'(wr_data[1]), 64'h0000000C);
      end

      // Full-capacity load at full rate
      @(posedge clk); #1;
      do_start();
      words.delete();
      for (int k = 0; k < CAP; k++) words.push_back({k[7:0], 8'h5A, ~k[7:0], 8'(k * 3)});
      build(32'(CAP), 1'b1);
      nogap = 1'b1;
      send(0, stream.size(), 1'b0);
      wait_end(20, lat);
      nogap = 1'b0;
      chk("full_done", 64'(done), 64'd1);
      chk("full_words_loaded", 64'(words_loaded), 64'(CAP));
      chk("full_nwrites", 64'(wr_data.size()), 64'(CAP));
      if (wr_data.size() == CAP) begin
         chk("full_last_addr", 64'(wr_addr[CAP-1]), 64'd31);
         chk("full_last_word", 64'(wr_data[CAP-1]), 64'h1F5AE05D);
      end

      // start during header is ignored
      @(posedge clk); #1;
      do_start();
      load_example();
      send(0, 2, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("hdr_start_busy", 64'(busy), 64'd1);
      send(2, stream.size(), 1'b0);
      wait_end(20, lat);
      chk("hdr_start_done", 64'(done), 64'd1);
      chk("hdr_start_nwrites", 64'(wr_data.size()), 64'd2);

      // Reset after six data bytes
      @(posedge clk); #1;
      do_start();
      load_example();
      send(0, 10, 1'b0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals();
      repeat (4) @(negedge clk);
      chk("midrst_nwrites", 64'(wr_data.size()), 64'd1);
      chk("midrst_cpu_reset", 64'(cpu_reset), 64'd1);

`ifdef IM_LOADER_CHECKSUM_EN
      // Wrong checksum byte
      @(posedge clk); #1;
      do_start();
      load_example();
      stream[stream.size()-1] = 8'h00;
      send(0, stream.size(), 1'b0);
      wait_end(20, lat);
      chk("badchk_latency", 64'(lat), 64'd1);
      chk("badchk_error", 64'(error), 64'd1);
      chk("badchk_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("badchk_nwrites", 64'(wr_data.size()), 64'd2);
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/im_loader.md
# im_loader

Boot-time program loader that is the writing end of the instruction-memory interface the single-cycle core reads from. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset while loading and releases it only after the final word is committed. It sits between a host byte source (UART/JTAG bridge) and the IM write port, next to the core's reset input.

## Interface
Parameters:
- ADDR_W, 5, IM word-address width; capacity 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  byte source has in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle.
- im_we  out  1  IM write strobe, one cycle per word.
- im_addr  out  ADDR_W  IM word address.
- im_wdata  out  32  IM write data.
- cpu_reset  out  1  core reset; high unless state is DONE.
- busy  out  1  state is HDR, DATA, FLUSH or CHK.
- done  out  1  state is DONE.
- error  out  1  state is ERR.
- words_loaded  out  ADDR_W+1  words written in the current load.

## Operation
- Byte accepted on a rising edge where in_valid && in_ready. in_ready is never asserted outside HDR, DATA and CHK. Unaccepted bytes are not consumed.
- Words are big-endian: the first byte accepted maps to [31:24].
- States and transitions:
  - IDLE: reset state. start → HDR.
  - HDR: accept 4 bytes to form word count N.
    - N == 0 or N > 2**ADDR_W → ERR.
    - Otherwise → DATA.
  - DATA: each 4th accepted byte registers im_we=1, im_addr=word index, im_wdata=word.
    - On the Nth word → FLUSH.
    - Otherwise remain in DATA with in_ready=1.
  - FLUSH: in_ready=0. Deasserts im_we. → CHK if checksum is compiled in, else → DONE.
  - DONE: cpu_reset=0. start → HDR.
  - ERR: cpu_reset=1. start → HDR.
- start while busy is ignored. On start from DONE, cpu_reset rises on the edge that enters HDR.
- Counters:
  - words_loaded cleared on entry to HDR; increments on each im_we.
  - Byte-lane counter wraps 3→0.
  - Word index equals words_loaded. N = 2**ADDR_W is legal: last address is all ones, and words_loaded saturates at N.
- Reset mid-load: return to IDLE, partial word discarded, IM contents already written are left unchanged, cpu_reset=1.
- Reset values: in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0.

## Timing
- All outputs registered.
- im_we is high exactly one cycle, starting the cycle after the edge that accepted a word's 4th byte.
- Back-to-back words at full rate: one word per 4 cycles, no bubbles.
- Without checksum: cpu_reset falls 2 cycles after the edge accepting the last data byte (edge+1 FLUSH, edge+2 DONE).
- With checksum: cpu_reset falls 1 cycle after the edge accepting the checksum byte, if the checksum matches.
- Header error: error rises 1 cycle after the 4th header byte is accepted.
- No IM write is ever issued while cpu_reset=0.

## Configuration
- IM_LOADER_CHECKSUM_EN defined:
  - CHK state follows FLUSH. It accepts one byte that must equal the XOR of all 4N data bytes (header excluded).
  - Match → DONE; mismatch → ERR.
- Undefined:
  - No CHK state, no checksum byte consumed.
  - FLUSH → DONE directly. ERR is reachable only via an illegal header.

## Test plan
- Reset, start, header 00 00 00 02, data 24 08 00 05 / 00 00 00 0C (checksum build: final byte 0x25) → im_we pulses at addr 0 wdata 0x24080005, then addr 1 wdata 0x0000000C; words_loaded=2; done=1, cpu_reset=0.
- Header 00 00 00 00, and separately 00 00 00 21 with ADDR_W=5 → error=1, cpu_reset=1, no im_we. A following start plus a valid stream → DONE.
- Full load N=32 with in_valid held high → 32 writes, addresses 0..31, one every 4 cycles, last at address 31, words_loaded=32.
- Random in_valid gaps, with in_valid asserted while in IDLE/DONE → same IM writes as the gap-free run; no bytes accepted outside HDR/DATA/CHK.
- reset asserted after 6 data bytes → next cycle IDLE, all outputs at reset values, no im_we for the partial word.
- IM_LOADER_CHECKSUM_EN build with a wrong checksum byte (0x00 instead of 0x25) → error=1, cpu_reset stays 1; a start during HDR is ignored.
